// File: rtl/block_mem_responder_pkg.sv
// Shared definitions for the block-memory responder and the cache that talks to it,
// so block packing and index widths agree on both ends of the refill/writeback port.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_DATA_W      = 32;

    function automatic int block_idx_w(input int words, input int block_words);
        int n;
        n = words / block_words;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_mem_responder.sv
// Main-memory responder: whole-block reads and writes with a fixed access latency,
// results returned through a valid/ready response handshake.
module block_mem_responder
    import mem_pkg::*;
#(
    parameter int WORDS       = 64,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LATENCY     = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_write,
    input  logic [block_idx_w(WORDS, BLOCK_WORDS)-1:0] req_block,
    input  logic [DATA_W*BLOCK_WORDS-1:0]            req_wdata,
    output logic                                     resp_valid,
    input  logic                                     resp_ready,
    output logic [DATA_W*BLOCK_WORDS-1:0]            resp_rdata
);

    localparam int BLK_W   = block_idx_w(WORDS, BLOCK_WORDS);
    localparam int ADDR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BLOCK_W = DATA_W * BLOCK_WORDS;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [DATA_W-1:0] memory [0:WORDS-1];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [BLK_W-1:0]   block_q, block_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic [BLOCK_W-1:0] stored_block;
    logic               commit;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;

    // A reset landing on the final busy edge discards the write rather than committing it.
    assign commit = (state_q == BUSY) && (cnt_q == '0) && write_q && reset;

    always_comb begin
        stored_block = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            stored_block[DATA_W*k +: DATA_W] =
                memory[ADDR_W'(int'(block_q) * BLOCK_WORDS + k)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        block_d = block_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    block_d = req_block;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = write_q ? wdata_q : stored_block;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            block_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            block_q <= block_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Backing store is deliberately outside reset so committed data survives it.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                memory[ADDR_W'(int'(block_q) * BLOCK_WORDS + k)] <= wdata_q[DATA_W*k +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: a transaction-level memory model checked every
// cycle, directed scenarios with literal expectations, and a LATENCY=1 instance for the bound.
module tb_block_mem_responder;

    localparam int LAT = 4;
    localparam int BW  = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [3:0]    req_block = '0;
    logic [BW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [BW-1:0] resp_rdata;

    logic          l1_req_valid = 1'b0;
    logic          l1_req_ready;
    logic          l1_req_write = 1'b0;
    logic [3:0]    l1_req_block = '0;
    logic [BW-1:0] l1_req_wdata = '0;
    logic          l1_resp_valid;
    logic          l1_resp_ready = 1'b0;
    logic [BW-1:0] l1_resp_rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    block_mem_responder #(.WORDS(64), .BLOCK_WORDS(4), .DATA_W(32), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_block  (req_block),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
    );

    block_mem_responder #(.WORDS(64), .BLOCK_WORDS(4), .DATA_W(32), .LATENCY(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_write  (l1_req_write),
        .req_block  (l1_req_block),
        .req_wdata  (l1_req_wdata),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_rdata (l1_resp_rdata)
    );

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Transaction model: a word array plus "cycles left until the response appears".
    logic [31:0]   mdl_mem [64];
    int            mdl_wait = 0;
    bit            mdl_resp = 1'b0;
    logic [BW-1:0] mdl_rdata = '0;
    bit            mdl_wr = 1'b0;
    int            mdl_blk = 0;
    logic [BW-1:0] mdl_wd = '0;

    initial forever begin
        @(posedge clock);
        if (!reset) begin
            mdl_wait  = 0;
            mdl_resp  = 1'b0;
            mdl_rdata = '0;
        end else if (mdl_resp) begin
            if (resp_ready) mdl_resp = 1'b0;
        end else if (mdl_wait > 0) begin
            mdl_wait--;
            if (mdl_wait == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (mdl_wr) mdl_mem[mdl_blk*4 + k] = mdl_wd[32*k +: 32];
                    mdl_rdata[32*k +: 32] = mdl_mem[mdl_blk*4 + k];
                end
                mdl_resp = 1'b1;
            end
        end else if (req_valid) begin
            mdl_wr   = req_write;
            mdl_blk  = int'(req_block);
            mdl_wd   = req_wdata;
            mdl_wait = LAT;
        end
    end

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("mdl_req_ready", BW'(req_ready), BW'(mdl_wait == 0 && !mdl_resp));
            checkOutput("mdl_resp_valid", BW'(resp_valid), BW'(mdl_resp));
            if (mdl_resp) checkOutput("mdl_resp_rdata", resp_rdata, mdl_rdata);
        end
    end

    // One full transaction on the LATENCY=4 instance; stall>0 holds resp_ready low that many cycles.
    task automatic applyStimulus(input bit wr, input logic [3:0] blk, input logic [BW-1:0] wd,
                                 input int stall, output logic [BW-1:0] rd,
                                 output int acc_cyc, output int lat);
        bit ok;
        logic [BW-1:0] held;
        rd = '0;
        acc_cyc = 0;
        lat = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_block  = blk;
        req_wdata  = wd;
        resp_ready = (stall == 0);
        ok = 1'b0;
        for (int g = 0; g < 40 && !ok; g++) begin
            @(negedge clock);
            if (req_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checkOutput("accept_timeout", BW'(0), BW'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_block = 4'($urandom_range(0, 15));
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        ok = 1'b0;
        for (int g = 0; g < 40 && !ok; g++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checkOutput("resp_timeout", BW'(0), BW'(1));
            return;
        end
        lat  = cyc - acc_cyc;
        rd   = resp_rdata;
        held = resp_rdata;
        for (int s = 0; s < stall; s++) begin
            if (s == 1) req_valid = 1'b1;
            @(negedge clock);
            checkOutput("stall_resp_valid", BW'(resp_valid), BW'(1));
            checkOutput("stall_resp_rdata", resp_rdata, held);
            checkOutput("stall_req_ready", BW'(req_ready), BW'(0));
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BW-1:0] wd;
        logic [BW-1:0] rd;
        int acc;
        int lat;
        int acc_prev;
        int l1_acc;

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        checkOutput("reset_req_ready", BW'(req_ready), BW'(1));
        checkOutput("reset_resp_valid", BW'(resp_valid), BW'(0));
        checkOutput("reset_resp_rdata", resp_rdata, BW'(0));
        reset = 1'b1;

        // Fill every block so word a holds a+6 (block 1 = 10,11,12,13).
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 4; k++) wd[32*k +: 32] = 32'(b*4 + k + 6);
            applyStimulus(1'b1, 4'(b), wd, 0, rd, acc, lat);
            checkOutput("preload_echo", rd, wd);
        end

        applyStimulus(1'b0, 4'd1, '0, 0, rd, acc, lat);
        checkOutput("read_b1_latency", BW'(lat), BW'(4));
        checkOutput("read_b1_data", rd, {32'd13, 32'd12, 32'd11, 32'd10});

        applyStimulus(1'b1, 4'd3, {32'd103, 32'd102, 32'd101, 32'd100}, 0, rd, acc, lat);
        checkOutput("write_b3_echo", rd, {32'd103, 32'd102, 32'd101, 32'd100});
        checkOutput("write_b3_mem12", BW'(dut.memory[12]), BW'(100));
        checkOutput("write_b3_mem15", BW'(dut.memory[15]), BW'(103));
        applyStimulus(1'b0, 4'd3, '0, 0, rd, acc, lat);
        checkOutput("read_b3_data", rd, {32'd103, 32'd102, 32'd101, 32'd100});

        applyStimulus(1'b0, 4'd2, '0, 5, rd, acc, lat);
        checkOutput("stall_b2_data", rd, {32'd17, 32'd16, 32'd15, 32'd14});

        // Reset two cycles after accepting a write of 7s to block 0.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_block = 4'd0;
        req_wdata = {4{32'd7}};
        @(negedge clock);
        checkOutput("rstw_pre_ready", BW'(req_ready), BW'(1));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rstw_req_ready", BW'(req_ready), BW'(1));
        checkOutput("rstw_resp_valid", BW'(resp_valid), BW'(0));
        checkOutput("rstw_resp_rdata", resp_rdata, BW'(0));
        reset = 1'b1;
        checkOutput("rstw_mem0", BW'(dut.memory[0]), BW'(6));
        applyStimulus(1'b0, 4'd0, '0, 0, rd, acc, lat);
        checkOutput("rstw_read_b0", rd, {32'd9, 32'd8, 32'd7, 32'd6});

        applyStimulus(1'b1, 4'd15, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000},
                      0, rd, acc, lat);
        acc_prev = acc;
        applyStimulus(1'b0, 4'd15, '0, 0, rd, acc, lat);
        checkOutput("b2b_issue_gap", BW'(acc - acc_prev), BW'(6));
        checkOutput("b2b_read_b15", rd, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000});
        checkOutput("b15_mem60", BW'(dut.memory[60]), BW'(32'hDEAD0000));
        checkOutput("b15_mem63", BW'(dut.memory[63]), BW'(32'hDEAD0003));

        for (int t = 0; t < 60; t++) begin
            wd = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wd,
                          int'($urandom_range(0, 3)), rd, acc, lat);
            checkOutput("rand_latency", BW'(lat), BW'(4));
        end

        // LATENCY=1 instance: write then read block 15.
        l1_req_valid  = 1'b1;
        l1_req_write  = 1'b1;
        l1_req_block  = 4'd15;
        l1_req_wdata  = {32'd63, 32'd62, 32'd61, 32'd60};
        l1_resp_ready = 1'b1;
        @(negedge clock);
        checkOutput("l1_w_ready", BW'(l1_req_ready), BW'(1));
        @(posedge clock);
        #1;
        l1_acc = cyc;
        l1_req_valid = 1'b0;
        @(negedge clock);
        checkOutput("l1_w_busy", BW'(l1_resp_valid), BW'(0));
        @(negedge clock);
        checkOutput("l1_w_valid", BW'(l1_resp_valid), BW'(1));
        checkOutput("l1_w_latency", BW'(cyc - l1_acc), BW'(1));
        checkOutput("l1_w_echo", l1_resp_rdata, {32'd63, 32'd62, 32'd61, 32'd60});
        checkOutput("l1_mem60", BW'(dut1.memory[60]), BW'(60));
        checkOutput("l1_mem63", BW'(dut1.memory[63]), BW'(63));
        @(posedge clock);
        #1;
        l1_req_valid = 1'b1;
        l1_req_write = 1'b0;
        @(negedge clock);
        checkOutput("l1_r_ready", BW'(l1_req_ready), BW'(1));
        @(posedge clock);
        #1;
        l1_req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("l1_r_valid", BW'(l1_resp_valid), BW'(1));
        checkOutput("l1_r_data", l1_resp_rdata, {32'd63, 32'd62, 32'd61, 32'd60});
        @(posedge clock);
        #1;
        l1_resp_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
